// File: rtl/fxp80s_pkg.sv
// rtl/fxp80s_pkg.sv - shared fxp80s word format constants and normalisation bundle
package fxp80s_pkg;

  localparam int FXP80S_WIDTH      = 80;
  localparam int FXP80S_SIGN       = 79;
  localparam int FXP80S_MAG_MSB    = 78;
  localparam int FXP80S_LSB_POW    = -48;
  localparam int FXP80S_SHIFT_BITS = 7;
  localparam int FXP80S_EXP_BITS   = 8;

  // Bundle consumed by the shifter wrapper; |exp| <= 78 always fits in 8 signed bits.
  typedef struct packed {
    logic [FXP80S_WIDTH-1:0]             data;
    logic [FXP80S_SHIFT_BITS-1:0]        shift;
    logic                                shift_sign;
    logic signed [FXP80S_EXP_BITS-1:0]   exp;
    logic                                zero;
  } fxp80s_norm_t;

endpackage

// File: rtl/fxp_lzc16.sv
// rtl/fxp_lzc16.sv - combinational 16-bit leading-zero counter with all-zero flag
module fxp_lzc16 (
  input  logic [15:0] data,
  output logic [4:0]  count,
  output logic        zero
);

  always_comb begin
    count = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data[i]) count = 5'(15 - i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/fxp80s_norm_ctrl.sv
// rtl/fxp80s_norm_ctrl.sv - two-stage leading-one finder producing shift/exponent for the fxp80s shifter
module fxp80s_norm_ctrl
  import fxp80s_pkg::*;
#(
  parameter int NORM_POS = 78,
  parameter int EXP_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FXP80S_WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FXP80S_WIDTH-1:0]  out_data,
  output logic [FXP80S_WIDTH-1:0]  out_shift,
  output logic                     out_shift_sign,
  output logic [EXP_W-1:0]         out_exp,
  output logic                     out_zero
);

  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s2_can_load;
  logic [FXP80S_WIDTH-1:0] s1_data;
  logic [4:0]              s1_cnt [5];
  logic [4:0]              s1_zero;
  logic [15:0]             grp [5];
  logic [4:0]              grp_cnt [5];
  logic [4:0]              grp_zero;
  fxp80s_norm_t            s2_q;
  fxp80s_norm_t            s2_d;
  logic [6:0]              lzc;
  int                      diff;

  // Top group holds only 15 magnitude bits; padding at the bottom keeps its count exact.
  assign grp[4] = {in_data[FXP80S_MAG_MSB:64], 1'b0};
  assign grp[3] = in_data[63:48];
  assign grp[2] = in_data[47:32];
  assign grp[1] = in_data[31:16];
  assign grp[0] = in_data[15:0];

  for (genvar g = 0; g < 5; g++) begin : g_lzc
    fxp_lzc16 u_lzc (
      .data  (grp[g]),
      .count (grp_cnt[g]),
      .zero  (grp_zero[g])
    );
  end

  assign s2_can_load = ~s2_valid | out_ready;
  assign in_ready    = ~s1_valid | s2_can_load;

  always_comb begin
    lzc = 7'd79;
    if (!s1_zero[4])      lzc = 7'(s1_cnt[4]);
    else if (!s1_zero[3]) lzc = 7'd15 + 7'(s1_cnt[3]);
    else if (!s1_zero[2]) lzc = 7'd31 + 7'(s1_cnt[2]);
    else if (!s1_zero[1]) lzc = 7'd47 + 7'(s1_cnt[1]);
    else if (!s1_zero[0]) lzc = 7'd63 + 7'(s1_cnt[0]);

    // diff > 0 means the leading one sits above NORM_POS and must move right.
    diff = (FXP80S_MAG_MSB - int'(lzc)) - NORM_POS;

    s2_d      = '0;
    s2_d.data = s1_data;
    s2_d.zero = &s1_zero;
    if (!s2_d.zero) begin
      s2_d.shift      = (diff < 0) ? 7'(-diff) : 7'(diff);
      s2_d.shift_sign = (diff > 0);
      s2_d.exp        = 8'(diff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '{default: '0};
      s1_zero  <= '0;
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_cnt  <= grp_cnt;
          s1_zero <= grp_zero;
        end
      end
      if (s2_can_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  assign out_valid      = s2_valid;
  assign out_data       = s2_q.data;
  assign out_shift      = {{(FXP80S_WIDTH-FXP80S_SHIFT_BITS){1'b0}}, s2_q.shift};
  assign out_shift_sign = s2_q.shift_sign;
  assign out_exp        = EXP_W'(s2_q.exp);
  assign out_zero       = s2_q.zero;

endmodule
